// File: rtl/stopwatch_counter_pkg.sv
// Shared constants and FSM encoding for the stopwatch counter.
package stopwatch_counter_pkg;

  localparam int unsigned FIELD_W     = 6;
  localparam int unsigned DEF_MAX_MIN = 59;
  localparam int unsigned DEF_MAX_SEC = 59;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control ticks and time outputs exchanged between the stopwatch and its environment.
interface stopwatch_counter_if;
  import stopwatch_counter_pkg::*;

  logic               tick_1hz;
  logic               tick_2hz;
  logic               pause;
  logic               adj;
  logic               sel;
  logic [FIELD_W-1:0] minute;
  logic [FIELD_W-1:0] second;
  logic               running;

  modport master (
    output tick_1hz, tick_2hz, pause, adj, sel,
    input  minute, second, running
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause, adj, sel,
    output minute, second, running
  );
endinterface

// File: rtl/stopwatch_counter_mod_n_counter.sv
// Modulo-(MAX+1) counter field; at MAX it wraps when wrap_en is set, otherwise holds.
module mod_n_counter #(
  parameter int unsigned W   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         wrap_en,
  output logic [W-1:0] value,
  output logic         carry_out
);

  logic at_max;

  assign at_max    = (value == W'(MAX));
  assign carry_out = inc && at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (inc) begin
      if (!at_max)      value <= value + W'(1);
      else if (wrap_en) value <= '0;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Minutes:seconds stopwatch with run/pause FSM and a per-field adjust mode.
// Build option: define STOPWATCH_ROLLOVER_EN to wrap MAX_MIN:MAX_SEC to 00:00 instead of saturating.
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned MAX_MIN = DEF_MAX_MIN,
  parameter int unsigned MAX_SEC = DEF_MAX_SEC
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_counter_if.slave  bus
);

`ifdef STOPWATCH_ROLLOVER_EN
  localparam bit ROLLOVER_EN = 1'b1;
`else
  localparam bit ROLLOVER_EN = 1'b0;
`endif

  state_t state, state_next;

  logic count_tick;
  logic sec_inc, min_inc;
  logic sec_wrap, min_wrap;
  logic sec_carry, min_carry;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.pause) begin
      case (state)
        ST_RUN:    state_next = ST_PAUSED;
        ST_PAUSED: state_next = ST_RUN;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  assign bus.running = (state == ST_RUN);

  // Normal counting carries seconds into minutes; adjust bumps only the selected field.
  assign count_tick = !bus.adj && (state == ST_RUN) && bus.tick_1hz;
  assign sec_inc    = count_tick || (bus.adj && bus.tick_2hz && bus.sel);
  assign min_inc    = (count_tick && sec_carry) || (bus.adj && bus.tick_2hz && !bus.sel);

  // Without rollover, a count tick at the full maximum freezes both fields.
  assign min_wrap = ROLLOVER_EN || bus.adj;
  assign sec_wrap = ROLLOVER_EN || bus.adj || !min_carry;

  mod_n_counter #(.W(FIELD_W), .MAX(MAX_SEC)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .inc       (sec_inc),
    .wrap_en   (sec_wrap),
    .value     (bus.second),
    .carry_out (sec_carry)
  );

  mod_n_counter #(.W(FIELD_W), .MAX(MAX_MIN)) u_min (
    .clk       (clk),
    .rst       (rst),
    .inc       (min_inc),
    .wrap_en   (min_wrap),
    .value     (bus.minute),
    .carry_out (min_carry)
  );

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter against a seconds-total reference model.
module tb_stopwatch_counter;

  localparam int MAXM = 59;
  localparam int MAXS = 59;

  logic clk = 1'b0;
  logic rst = 1'b0;

  stopwatch_counter_if bus ();

  stopwatch_counter #(.MAX_MIN(MAXM), .MAX_SEC(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int m_min  = 0;
  int m_sec  = 0;
  bit m_run  = 1'b1;

`ifdef STOPWATCH_ROLLOVER_EN
  localparam bit ROLL = 1'b1;
`else
  localparam bit ROLL = 1'b0;
`endif

  // Reference: counting works on total elapsed seconds; adjust is per-field modulo.
  task automatic model_step(input bit t1, t2, p, a, s, r);
    int total;
    if (r) begin
      m_min = 0; m_sec = 0; m_run = 1'b1;
    end else begin
      if (!a && m_run && t1) begin
        total = m_min * (MAXS + 1) + m_sec;
        if (total == (MAXM + 1) * (MAXS + 1) - 1) total = ROLL ? 0 : total;
        else                                     total = total + 1;
        m_min = total / (MAXS + 1);
        m_sec = total % (MAXS + 1);
      end
      if (a && t2) begin
        if (s) m_sec = (m_sec + 1) % (MAXS + 1);
        else   m_min = (m_min + 1) % (MAXM + 1);
      end
      if (p) m_run = !m_run;
    end
  endtask

  task automatic step(input bit t1, t2, p, a, s, r);
    bus.tick_1hz = t1; bus.tick_2hz = t2; bus.pause = p;
    bus.adj = a; bus.sel = s; rst = r;
    model_step(t1, t2, p, a, s, r);
    @(posedge clk); #1;
    bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0; bus.pause = 1'b0; rst = 1'b0;
  endtask

  task automatic load(input int mm, input int ss);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < ss; i++) step(0, 1, 0, 1, 1, 0);
    for (int i = 0; i < mm; i++) step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.minute !== 6'd0 || bus.second !== 6'd0 || bus.running !== 1'b1)
      $display("FAIL reset: got %0d:%0d run=%b want 0:0 run=1", bus.minute, bus.second, bus.running);
    else passed++;
  endtask

  task automatic test_carry();
    load(0, 58);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.minute !== 6'd0 || bus.second !== 6'd59)
      $display("FAIL carry_first: got %0d:%0d want 0:59", bus.minute, bus.second);
    else passed++;
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.minute !== 6'd0 || bus.second !== 6'd59)
      $display("FAIL carry_idle: got %0d:%0d want 0:59", bus.minute, bus.second);
    else passed++;
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.minute !== 6'd1 || bus.second !== 6'd0)
      $display("FAIL carry_minute: got %0d:%0d want 1:0", bus.minute, bus.second);
    else passed++;
  endtask

  task automatic test_max();
    int wm, ws;
    load(59, 59);
    checks++;
    if (bus.minute !== 6'd59 || bus.second !== 6'd59)
      $display("FAIL max_load: got %0d:%0d want 59:59", bus.minute, bus.second);
    else passed++;
    step(1, 0, 0, 0, 0, 0);
    wm = ROLL ? 0 : 59;
    ws = ROLL ? 0 : 59;
    checks++;
    if (int'(bus.minute) != wm || int'(bus.second) != ws || bus.running !== 1'b1)
      $display("FAIL max_tick: got %0d:%0d run=%b want %0d:%0d run=1",
               bus.minute, bus.second, bus.running, wm, ws);
    else passed++;
  endtask

  task automatic test_pause_tick();
    load(3, 10);
    step(1, 0, 1, 0, 0, 0);
    checks++;
    if (bus.minute !== 6'd3 || bus.second !== 6'd11 || bus.running !== 1'b0)
      $display("FAIL pause_tick: got %0d:%0d run=%b want 3:11 run=0", bus.minute, bus.second, bus.running);
    else passed++;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.minute !== 6'd3 || bus.second !== 6'd11)
      $display("FAIL pause_hold: got %0d:%0d want 3:11", bus.minute, bus.second);
    else passed++;
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.second !== 6'd12 || bus.running !== 1'b1)
      $display("FAIL resume: got sec=%0d run=%b want sec=12 run=1", bus.second, bus.running);
    else passed++;
  endtask

  task automatic test_adjust();
    load(7, 59);
    step(1, 1, 0, 1, 1, 0);
    checks++;
    if (bus.minute !== 6'd7 || bus.second !== 6'd0)
      $display("FAIL adj_no_carry: got %0d:%0d want 7:0", bus.minute, bus.second);
    else passed++;
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    checks++;
    if (bus.minute !== 6'd9 || bus.second !== 6'd0)
      $display("FAIL adj_minute: got %0d:%0d want 9:0", bus.minute, bus.second);
    else passed++;
    step(0, 0, 1, 1, 0, 0);
    checks++;
    if (bus.running !== 1'b0)
      $display("FAIL adj_pause: got run=%b want 0", bus.running);
    else passed++;
    step(1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.minute !== 6'd9 || bus.second !== 6'd0 || bus.running !== 1'b1)
      $display("FAIL adj_exit: got %0d:%0d run=%b want 9:0 run=1", bus.minute, bus.second, bus.running);
    else passed++;
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.second !== 6'd1)
      $display("FAIL adj_resume: got sec=%0d want 1", bus.second);
    else passed++;
  endtask

  task automatic test_reset_adjust();
    load(12, 34);
    step(1, 1, 1, 1, 1, 1);
    checks++;
    if (bus.minute !== 6'd0 || bus.second !== 6'd0 || bus.running !== 1'b1)
      $display("FAIL reset_adj: got %0d:%0d run=%b want 0:0 run=1", bus.minute, bus.second, bus.running);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    bit t1, t2, p, a, s, r;
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      t1 = ($urandom_range(0, 1) == 1);
      t2 = ($urandom_range(0, 3) == 0);
      p  = ($urandom_range(0, 15) == 0);
      a  = ($urandom_range(0, 7) == 0) ? !bus.adj : bus.adj;
      s  = ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 999) == 0);
      step(t1, t2, p, a, s, r);
      checks++;
      if (int'(bus.minute) != m_min || int'(bus.second) != m_sec || bus.running !== m_run) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random[%0d]: got %0d:%0d run=%b want %0d:%0d run=%b",
                   i, bus.minute, bus.second, bus.running, m_min, m_sec, m_run);
      end else passed++;
    end
  endtask

  initial begin
    bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0; bus.pause = 1'b0;
    bus.adj = 1'b0; bus.sel = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_carry();
    test_max();
    test_pause_tick();
    test_adjust();
    test_reset_adjust();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
